// File: rtl/timer_alarm_pkg.sv
// Shared definitions for the multi-channel alarm timer: command encodings,
// channel states and the wrap-safe elapsed-time helper.
package timer_alarm_pkg;

  localparam int CW_DEFAULT = 16;

  typedef enum logic [1:0] {
    OP_ARM_ONESHOT  = 2'd0,
    OP_ARM_PERIODIC = 2'd1,
    OP_CANCEL       = 2'd2,
    OP_ACK          = 2'd3
  } cmd_op_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ARMED = 1'b1
  } chan_state_e;

  // Modular subtraction keeps the comparison correct across counter wrap.
  function automatic logic [CW_DEFAULT-1:0] elapsed_ticks(
    input logic [CW_DEFAULT-1:0] now,
    input logic [CW_DEFAULT-1:0] start
  );
    return now - start;
  endfunction

endpackage

// File: rtl/timer_alarm_chan.sv
// One alarm channel: IDLE/ARMED state machine with one-shot and periodic
// expiry, sticky fired/overrun flags.
module timer_alarm_chan
  import timer_alarm_pkg::*;
#(
  parameter int CW = CW_DEFAULT
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [CW-1:0] count_i,
  input  logic          arm_i,
  input  logic          periodic_i,
  input  logic          cancel_i,
  input  logic          ack_i,
  input  logic [CW-1:0] delay_i,
  output logic          armed_o,
  output logic          fired_o,
  output logic          overrun_o
);

  chan_state_e   state_q, state_d;
  logic [CW-1:0] start_q, start_d;
  logic [CW-1:0] delay_q, delay_d;
  logic          periodic_q, periodic_d;
  logic          fired_q, fired_d;
  logic          overrun_q, overrun_d;
  logic [CW-1:0] elapsed;
  logic          expire;

  assign elapsed = CW'(count_i - start_q);
  assign expire  = (state_q == ST_ARMED) && (elapsed >= delay_q);

  always_comb begin
    state_d    = state_q;
    start_d    = start_q;
    delay_d    = delay_q;
    periodic_d = periodic_q;
    fired_d    = fired_q;
    overrun_d  = overrun_q;

    if (ack_i) begin
      fired_d   = 1'b0;
      overrun_d = 1'b0;
    end

    // ARM and CANCEL both override a coinciding expiry.
    if (arm_i) begin
      state_d    = ST_ARMED;
      start_d    = count_i;
      delay_d    = delay_i;
      periodic_d = periodic_i && (delay_i != '0);
    end else if (cancel_i) begin
      state_d = ST_IDLE;
    end else if (expire) begin
      fired_d = 1'b1;
      if (fired_q && !ack_i) overrun_d = 1'b1;
      if (periodic_q) start_d = start_q + delay_q;
      else            state_d = ST_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      start_q    <= '0;
      delay_q    <= '0;
      periodic_q <= 1'b0;
      fired_q    <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      start_q    <= start_d;
      delay_q    <= delay_d;
      periodic_q <= periodic_d;
      fired_q    <= fired_d;
      overrun_q  <= overrun_d;
    end
  end

  assign armed_o   = (state_q == ST_ARMED);
  assign fired_o   = fired_q;
  assign overrun_o = overrun_q;

endmodule

// File: rtl/timer_alarm.sv
// Multi-channel alarm timer: decodes commands to per-channel strobes,
// synchronises reset release and registers the combined interrupt.
module timer_alarm
  import timer_alarm_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CW     = CW_DEFAULT
) (
  input  logic                                        clk,
  input  logic                                        reset,
  input  logic [CW-1:0]                               count_in,
  input  logic                                        cmd_valid,
  input  logic [1:0]                                  cmd_op,
  input  logic [$clog2(NUM_CH > 1 ? NUM_CH : 2)-1:0]  cmd_chan,
  input  logic [CW-1:0]                               cmd_delay,
  output logic [NUM_CH-1:0]                           fired,
  output logic [NUM_CH-1:0]                           overrun,
  output logic [NUM_CH-1:0]                           armed,
  output logic                                        irq
);

  logic [1:0] rst_sync_q;
  logic       rst_n_int;
  logic       irq_q;
  logic       op_arm, op_periodic, op_cancel, op_ack;

  // Assert asynchronously, release two edges after reset rises.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rst_sync_q <= 2'b00;
    else        rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n_int = rst_sync_q[1];

  assign op_arm      = (cmd_op == OP_ARM_ONESHOT) || (cmd_op == OP_ARM_PERIODIC);
  assign op_periodic = (cmd_op == OP_ARM_PERIODIC);
  assign op_cancel   = (cmd_op == OP_CANCEL);
  assign op_ack      = (cmd_op == OP_ACK);

  // A channel index beyond NUM_CH-1 matches no instance and is dropped.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic sel;
    assign sel = cmd_valid && (int'(cmd_chan) == i);

    timer_alarm_chan #(.CW(CW)) u_chan (
      .clk        (clk),
      .rst_n      (rst_n_int),
      .count_i    (count_in),
      .arm_i      (sel && op_arm),
      .periodic_i (op_periodic),
      .cancel_i   (sel && op_cancel),
      .ack_i      (sel && op_ack),
      .delay_i    (cmd_delay),
      .armed_o    (armed[i]),
      .fired_o    (fired[i]),
      .overrun_o  (overrun[i])
    );
  end

  always_ff @(posedge clk or negedge rst_n_int) begin
    if (!rst_n_int) irq_q <= 1'b0;
    else            irq_q <= |fired;
  end
  assign irq = irq_q;

endmodule

// File: doc/timer_alarm.md
TIMER_ALARM -- requirements
Module: timer_alarm

Interface
REQ-001 Parameter NUM_CH, default 4, number of independent alarm channels.
REQ-002 Parameter CW, default 16, width of timer count and delay values.
REQ-003 clk  input  1  system clock, 12.5 MHz; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset; the block is held reset while reset is low.
REQ-005 count_in  input  CW  live 100 us tick count from the upstream 100 us timer; wraps modulo 2^CW.
REQ-006 cmd_valid  input  1  command strobe; one command is accepted per cycle it is high.
REQ-007 cmd_op  input  2  command: 0 ARM_ONESHOT, 1 ARM_PERIODIC, 2 CANCEL, 3 ACK.
REQ-008 cmd_chan  input  clog2(NUM_CH)  target channel.
REQ-009 cmd_delay  input  CW  delay in 100 us ticks; used by the ARM commands only.
REQ-010 fired  output  NUM_CH  sticky per-channel expiry flags.
REQ-011 overrun  output  NUM_CH  sticky per-channel flag: expired again while fired was already set.
REQ-012 armed  output  NUM_CH  per-channel flag: channel in state ARMED.
REQ-013 irq  output  1  registered OR of all fired bits.

Function
REQ-014 Each channel SHALL have its own state machine with states IDLE and ARMED, plus registers start[CW], delay[CW], periodic, fired and overrun.
REQ-015 Commands SHALL always be accepted; there is no ready signal, and commands with cmd_chan >= NUM_CH SHALL be ignored.
REQ-016 ARM_* at edge E SHALL load start <= count_in and delay <= cmd_delay, set periodic (0 for ONESHOT, 1 for PERIODIC), and enter ARMED from any state; re-arming an ARMED channel restarts it.
REQ-017 ARM_PERIODIC with cmd_delay == 0 SHALL be treated as ARM_ONESHOT.
REQ-018 Elapsed time SHALL be computed as (count_in - start) mod 2^CW, so expiry is wrap-around safe for any delay of 0..2^CW-1.
REQ-019 An ARMED channel SHALL expire at the first edge where elapsed >= delay; fired is visible from that edge.
REQ-020 On one-shot expiry the channel SHALL go to IDLE.
REQ-021 On periodic expiry the channel SHALL stay ARMED with start <= start + delay (mod 2^CW), so there is no cumulative drift.
REQ-022 If expiry occurs while fired is already 1, overrun SHALL be set; fired stays 1.
REQ-023 ACK SHALL clear fired and overrun of the channel; it does not change the channel state.
REQ-024 If expiry and ACK on the same channel coincide in one cycle, the expiry SHALL win: fired = 1, and overrun is not set.
REQ-025 CANCEL SHALL force IDLE; fired and overrun are left unchanged.
REQ-026 If a CANCEL and an expiry coincide, the CANCEL SHALL win, the expiry is discarded and fired is unchanged.
REQ-027 ARM with delay 0 SHALL expire at the first edge after the arming edge.
REQ-028 irq SHALL equal the OR of fired delayed by one cycle.
REQ-029 Outputs armed, fired and overrun SHALL be registered.

Reset
REQ-030 While reset is low, all channels SHALL be IDLE and start, delay, periodic, fired, overrun, armed and irq SHALL be 0, independent of clk.
REQ-031 Reset asserted mid-countdown SHALL discard all pending alarms; no expiry is reported after release.
REQ-032 Reset release SHALL be synchronised before use, so the first active edge is deterministic.

Structure
REQ-033 A shared package SHALL hold the cmd_op encodings (OP_ARM_ONESHOT, OP_ARM_PERIODIC, OP_CANCEL, OP_ACK) and the default CW.
REQ-034 The channel SHALL be one sub-module, timer_alarm_chan, instantiated NUM_CH times with a generate loop; the top level decodes commands and ORs irq.

Verification
REQ-035 One-shot: count_in=100, ARM_ONESHOT ch0 delay=5 -> fired[0] rises at the edge where count_in=105; armed[0] drops at the same edge; irq is high one cycle later.
REQ-036 Wrap: count_in=0xFFFE, ARM_ONESHOT ch1 delay=4 -> fired[1] sets when count_in=0x0002, and not before.
REQ-037 Periodic: count_in=10, ARM_PERIODIC ch2 delay=3 -> expiries at 13, 16, 19; overrun[2] sets at 16 without an ACK; after ACK both flags clear and the next expiry at 22 sets only fired.
REQ-038 Collisions: ACK ch0 in the expiry cycle -> fired=1 and overrun=0; CANCEL ch3 in its expiry cycle -> fired[3]=0 and state IDLE.
REQ-039 Reset: ch0 armed with delay=50, reset pulsed low at elapsed=20 -> all outputs immediately 0 and no expiry within 100 ticks.
REQ-040 Edge cases: ARM delay=0 -> fired one edge after arming; cmd_chan=4 with NUM_CH=4 -> no state change.
